// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: MM:SS BCD stopwatch FSM (IDLE/RUN/PAUSED/ADJ); adjust mode enabled by macro STOPWATCH_ADJUST_EN
module stopwatch_ctrl #(
  parameter bit MIN_WRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_pulse,
  input  logic       clr_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       adjusting,
  output logic       blink
);
`ifdef STOPWATCH_ADJUST_EN
  localparam bit ADJ_EN = 1'b1;
`else
  localparam bit ADJ_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, ADJ} state_t;
  state_t r_state, w_nxt;
  logic [3:0] r_mt, r_mo, r_st, r_so, w_mt, w_mo, w_st, w_so;
  logic [7:0] w_sec, w_min;
  logic r_running, r_adjusting, r_blink, w_blink, w_adj, w_roll, w_max;
  function automatic logic [7:0] inc59(input logic [3:0] t, input logic [3:0] o);
    return (o == 4'd9) ? ((t == 4'd5) ? 8'h00 : {t + 4'd1, 4'd0}) : {t, o + 4'd1};
  endfunction
  assign w_adj = ADJ_EN && adj;
  assign w_sec = inc59(r_st, r_so);
  assign w_min = inc59(r_mt, r_mo);
  assign w_roll = (r_st == 4'd5) && (r_so == 4'd9);
  assign w_max = w_roll && (r_mt == 4'd5) && (r_mo == 4'd9);
  // next state, next digits and next blink phase; clear beats everything but reset
  always_comb begin
    w_nxt = r_state;
    {w_mt, w_mo, w_st, w_so} = {r_mt, r_mo, r_st, r_so};
    w_blink = 1'b0;
    if (clr_pulse) begin
      w_nxt = IDLE;
      {w_mt, w_mo, w_st, w_so} = 16'h0000;
    end else begin
      case (r_state)
        IDLE:   w_nxt = w_adj ? ADJ : (pause_pulse ? RUN : IDLE);
        PAUSED: w_nxt = w_adj ? ADJ : (pause_pulse ? RUN : PAUSED);
        RUN: begin
          w_nxt = pause_pulse ? PAUSED : RUN;
          if (tick_1hz) begin
            if (w_max && !MIN_WRAP) w_nxt = PAUSED;
            else begin
              {w_st, w_so} = w_sec;
              if (w_roll) {w_mt, w_mo} = w_min;
            end
          end
        end
        ADJ: begin
          w_nxt = w_adj ? ADJ : PAUSED;
          w_blink = w_adj && (r_blink ^ tick_2hz);
          if (w_adj && tick_2hz && sel) {w_mt, w_mo} = w_min;
          if (w_adj && tick_2hz && !sel) {w_st, w_so} = w_sec;
        end
        default: w_nxt = IDLE;
      endcase
    end
  end
  // state, digits and status flags all register together so flags track the state exactly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      {r_mt, r_mo, r_st, r_so} <= 16'h0000;
      r_running <= 1'b0;
      r_adjusting <= 1'b0;
      r_blink <= 1'b0;
    end else begin
      r_state <= w_nxt;
      {r_mt, r_mo, r_st, r_so} <= {w_mt, w_mo, w_st, w_so};
      r_running <= (w_nxt == RUN);
      r_adjusting <= (w_nxt == ADJ);
      r_blink <= w_blink;
    end
  end
  assign min_tens = r_mt;
  assign min_ones = r_mo;
  assign sec_tens = r_st;
  assign sec_ones = r_so;
  assign running = r_running;
  assign adjusting = ADJ_EN && r_adjusting;
  assign blink = ADJ_EN && r_blink;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: randomized + directed bench for stopwatch_ctrl, wrap and saturate instances side by side
module tb_stopwatch_ctrl;
`ifdef STOPWATCH_ADJUST_EN
  localparam bit ADJ_EN = 1'b1;
`else
  localparam bit ADJ_EN = 1'b0;
`endif
  typedef enum {M_IDLE, M_RUN, M_PAUSED, M_ADJ} mode_t;
  logic clk = 1'b0;
  logic rst_n, tick_1hz, tick_2hz, pause_pulse, clr_pulse, adj, sel;
  logic [3:0] mt[2], mo[2], st[2], so[2];
  logic run_o[2], adj_o[2], blink_o[2];
  mode_t m_mode[2];
  int m_cnt[2];
  bit m_blink[2];
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  stopwatch_ctrl #(.MIN_WRAP(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .pause_pulse(pause_pulse), .clr_pulse(clr_pulse), .adj(adj), .sel(sel),
    .min_tens(mt[0]), .min_ones(mo[0]), .sec_tens(st[0]), .sec_ones(so[0]),
    .running(run_o[0]), .adjusting(adj_o[0]), .blink(blink_o[0])
  );
  stopwatch_ctrl #(.MIN_WRAP(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .pause_pulse(pause_pulse), .clr_pulse(clr_pulse), .adj(adj), .sel(sel),
    .min_tens(mt[1]), .min_ones(mo[1]), .sec_tens(st[1]), .sec_ones(so[1]),
    .running(run_o[1]), .adjusting(adj_o[1]), .blink(blink_o[1])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] bcd(input int c);
    int m, s;
    m = c / 60;
    s = c % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction
  function automatic logic [15:0] dig(input int k);
    return {mt[k], mo[k], st[k], so[k]};
  endfunction
  // elapsed time kept as plain seconds 0..3599
  task automatic model_step(input int k, input bit wrap);
    if (!rst_n || clr_pulse) begin
      m_mode[k] = M_IDLE;
      m_cnt[k] = 0;
      m_blink[k] = 1'b0;
    end else begin
      case (m_mode[k])
        M_IDLE, M_PAUSED: begin
          if (ADJ_EN && adj) m_mode[k] = M_ADJ;
          else if (pause_pulse) m_mode[k] = M_RUN;
        end
        M_RUN: begin
          if (tick_1hz) begin
            if (m_cnt[k] < 3599) m_cnt[k] = m_cnt[k] + 1;
            else if (wrap) m_cnt[k] = 0;
            else m_mode[k] = M_PAUSED;
          end
          if (pause_pulse) m_mode[k] = M_PAUSED;
        end
        default: begin
          if (!adj) begin
            m_mode[k] = M_PAUSED;
            m_blink[k] = 1'b0;
          end else if (tick_2hz) begin
            m_blink[k] = !m_blink[k];
            if (sel) m_cnt[k] = ((m_cnt[k] / 60 + 1) % 60) * 60 + m_cnt[k] % 60;
            else m_cnt[k] = (m_cnt[k] / 60) * 60 + (m_cnt[k] % 60 + 1) % 60;
          end
        end
      endcase
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("digits[%0d]", k), dig(k), bcd(m_cnt[k]));
      chk($sformatf("running[%0d]", k), run_o[k], m_mode[k] == M_RUN);
      chk($sformatf("adjusting[%0d]", k), adj_o[k], m_mode[k] == M_ADJ);
      chk($sformatf("blink[%0d]", k), blink_o[k], m_blink[k]);
    end
    {tick_1hz, tick_2hz, pause_pulse, clr_pulse} = 4'b0000;
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      tick_1hz = 1'b1;
      cyc();
    end
  endtask
  initial begin
    {tick_1hz, tick_2hz, pause_pulse, clr_pulse, adj, sel} = 6'b0;
    rst_n = 1'b0;
    cyc();
    cyc();
    chk("reset_digits", dig(0), 16'h0000);
    chk("reset_running", run_o[0], 1'b0);
    rst_n = 1'b1;
    pause_pulse = 1'b1;
    cyc();
    repeat (75) begin
      repeat ($urandom_range(2)) cyc();
      tick_1hz = 1'b1;
      cyc();
    end
    chk("count_75", dig(0), 16'h0115);
    chk("count_75_run", run_o[0], 1'b1);
    clr_pulse = 1'b1;
    cyc();
    pause_pulse = 1'b1;
    cyc();
    ticks(7);
    pause_pulse = 1'b1;
    tick_1hz = 1'b1;
    cyc();
    chk("pause_tick", dig(0), 16'h0008);
    chk("pause_tick_run", run_o[0], 1'b0);
    ticks(3);
    chk("paused_hold", dig(0), 16'h0008);
    clr_pulse = 1'b1;
    cyc();
    pause_pulse = 1'b1;
    cyc();
    ticks(754);
    chk("at_1234", dig(0), 16'h1234);
    clr_pulse = 1'b1;
    pause_pulse = 1'b1;
    cyc();
    chk("clr_beats_pause", dig(0), 16'h0000);
    chk("clr_idle", run_o[0], 1'b0);
    pause_pulse = 1'b1;
    cyc();
    ticks(5);
    rst_n = 1'b0;
    tick_1hz = 1'b1;
    pause_pulse = 1'b1;
    cyc();
    chk("rst_mid_count", {dig(0), run_o[0], adj_o[0], blink_o[0]}, 19'h0);
    rst_n = 1'b1;
    pause_pulse = 1'b1;
    cyc();
    ticks(3598);
    chk("at_5958", dig(1), 16'h5958);
    ticks(2);
    chk("wrap_digits", dig(0), 16'h0000);
    chk("wrap_run", run_o[0], 1'b1);
    chk("sat_digits", dig(1), 16'h5959);
    chk("sat_run", run_o[1], 1'b0);
    ticks(2);
    chk("sat_hold", dig(1), 16'h5959);
    clr_pulse = 1'b1;
    cyc();
`ifdef STOPWATCH_ADJUST_EN
    pause_pulse = 1'b1;
    cyc();
    ticks(58);
    pause_pulse = 1'b1;
    cyc();
    adj = 1'b1;
    sel = 1'b0;
    cyc();
    repeat (3) begin
      tick_2hz = 1'b1;
      cyc();
    end
    chk("adj_sec", dig(0), 16'h0001);
    chk("adj_blink", blink_o[0], 1'b1);
    chk("adj_flag", adj_o[0], 1'b1);
    adj = 1'b0;
    cyc();
    chk("adj_exit", adj_o[0], 1'b0);
    chk("adj_exit_digits", dig(0), 16'h0001);
`else
    adj = 1'b1;
    repeat (4) begin
      tick_2hz = 1'b1;
      cyc();
    end
    chk("noadj_digits", dig(0), 16'h0000);
    chk("noadj_flags", {run_o[0], adj_o[0], blink_o[0]}, 3'b000);
    adj = 1'b0;
`endif
    repeat (3000) begin
      rst_n = ($urandom_range(199) != 0);
      clr_pulse = ($urandom_range(49) == 0);
      pause_pulse = ($urandom_range(19) == 0);
      tick_1hz = ($urandom_range(2) == 0);
      tick_2hz = ($urandom_range(3) == 0);
      sel = 1'($urandom_range(1));
      if ($urandom_range(29) == 0) adj = ~adj;
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
